way_select_controller: RTL and testbench

//  Sequences one L2 lookup per request: reads the per-set tag array, compares all ways and picks hit or victim way.

---
 rtl/cache_pkg.sv | 15 +
 rtl/way_select_controller_plru_tree.sv | 60 ++++++
 rtl/way_select_controller.sv | 130 +++++++++++++
 tb/tb_way_select_controller.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared parameters and the controller state encoding for the L2 way-select path.
package cache_pkg;

    localparam int WAYS_DEFAULT     = 8;
    localparam int TAG_BITS_DEFAULT = 12;
    localparam int SET_BITS_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAG_RD  = 2'd1,
        COMPARE = 2'd2,
        RESP    = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/way_select_controller_plru_tree.sv
// Per-set tree pseudo-LRU state: combinational victim lookup for one set and a
// registered path update for another.
module plru_tree
    import cache_pkg::*;
#(
    parameter int WAYS     = WAYS_DEFAULT,
    parameter int SET_BITS = SET_BITS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SET_BITS-1:0]      rd_set_i,
    output logic [$clog2(WAYS)-1:0]  victim_o,
    input  logic                     upd_en_i,
    input  logic [SET_BITS-1:0]      upd_set_i,
    input  logic [$clog2(WAYS)-1:0]  upd_way_i
);

    localparam int WB    = $clog2(WAYS);
    localparam int NODES = WAYS - 1;
    localparam int SETS  = 1 << SET_BITS;

    logic [NODES-1:0] bits_q [SETS];
    logic [NODES-1:0] upd_bits_d;

    // Trees are padded to 2*WAYS bits so a heap index of WB+1 bits covers leaves too.
    always_comb begin
        logic [2*WAYS-1:0] ext;
        logic [WB:0]       node;
        ext  = {{(2*WAYS-NODES){1'b0}}, bits_q[rd_set_i]};
        node = '0;
        for (int l = 0; l < WB; l++) begin
            node = (node << 1) + (WB+1)'(1) + {{WB{1'b0}}, ext[node]};
        end
        victim_o = WB'(node - (WB+1)'(NODES));
    end

    always_comb begin
        logic [2*WAYS-1:0] ext;
        logic [WB:0]       idx;
        logic [WB-1:0]     sh;
        ext = {{(2*WAYS-NODES){1'b0}}, bits_q[upd_set_i]};
        idx = '0;
        sh  = '0;
        for (int l = 0; l < WB; l++) begin
            idx      = (WB+1)'((1 << l) - 1) + (WB+1)'(upd_way_i >> (WB - l));
            sh       = upd_way_i >> (WB - 1 - l);
            ext[idx] = ~sh[0];
        end
        upd_bits_d = ext[NODES-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
        end else if (upd_en_i) begin
            bits_q[upd_set_i] <= upd_bits_d;
        end
    end

endmodule

// File: rtl/way_select_controller.sv
// One-at-a-time L2 tag lookup: reads the set's tags, picks the hit or victim way,
// presents it to the way mux and updates the set's PLRU tree on handshake.
module way_select_controller
    import cache_pkg::*;
#(
    parameter int WAYS     = WAYS_DEFAULT,
    parameter int TAG_BITS = TAG_BITS_DEFAULT,
    parameter int SET_BITS = SET_BITS_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [SET_BITS-1:0]       req_set,
    input  logic [TAG_BITS-1:0]       req_tag,
    output logic                      tag_rd_en,
    output logic [SET_BITS-1:0]       tag_rd_set,
    input  logic [WAYS*TAG_BITS-1:0]  way_tags,
    input  logic [WAYS-1:0]           way_valid,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_hit,
    output logic [$clog2(WAYS)-1:0]   rsp_way,
    output logic                      rsp_multihit
);

    localparam int WB = $clog2(WAYS);

    ctrl_state_t         state_q, state_d;
    logic [SET_BITS-1:0] set_q, set_d;
    logic [TAG_BITS-1:0] tag_q, tag_d;
    logic                hit_q, hit_d;
    logic [WB-1:0]       way_q, way_d;
    logic                mh_q, mh_d;

    logic [WAYS-1:0]     match;
    logic [WB-1:0]       hit_way;
    logic [WB-1:0]       inv_way;
    logic [WB-1:0]       victim;
    logic                plru_upd;

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            match[w] = way_valid[w] && (way_tags[w*TAG_BITS +: TAG_BITS] == tag_q);
        end
    end

    // Descending scan leaves the lowest-index candidate in place.
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w])      hit_way = WB'(w);
            if (!way_valid[w]) inv_way = WB'(w);
        end
    end

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        tag_d   = tag_q;
        hit_d   = hit_q;
        way_d   = way_q;
        mh_d    = mh_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    set_d   = req_set;
                    tag_d   = req_tag;
                    state_d = TAG_RD;
                end
            end
            TAG_RD: state_d = COMPARE;
            COMPARE: begin
                hit_d   = |match;
                mh_d    = |(match & (match - WAYS'(1)));
                if (|match)          way_d = hit_way;
                else if (~&way_valid) way_d = inv_way;
                else                 way_d = victim;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            set_q   <= '0;
            tag_q   <= '0;
            hit_q   <= 1'b0;
            way_q   <= '0;
            mh_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            tag_q   <= tag_d;
            hit_q   <= hit_d;
            way_q   <= way_d;
            mh_q    <= mh_d;
        end
    end

    assign plru_upd = (state_q == RESP) && rsp_ready;

    plru_tree #(
        .WAYS     (WAYS),
        .SET_BITS (SET_BITS)
    ) u_plru (
        .clk       (clk),
        .reset     (reset),
        .rd_set_i  (set_q),
        .victim_o  (victim),
        .upd_en_i  (plru_upd),
        .upd_set_i (set_q),
        .upd_way_i (way_q)
    );

    assign req_ready    = (state_q == IDLE);
    assign tag_rd_en    = (state_q == TAG_RD);
    assign tag_rd_set   = set_q;
    assign rsp_valid    = (state_q == RESP);
    assign rsp_hit      = hit_q;
    assign rsp_way      = way_q;
    assign rsp_multihit = mh_q;

endmodule

// File: tb/tb_way_select_controller.sv
// Directed bench for way_select_controller: latency, hit/miss/victim choice,
// PLRU sequencing, backpressure and mid-lookup reset.
module tb_way_select_controller;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_set;
    logic [11:0] req_tag;
    logic        tag_rd_en;
    logic [3:0]  tag_rd_set;
    logic [95:0] way_tags;
    logic [7:0]  way_valid;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic [2:0]  rsp_way;
    logic        rsp_multihit;

    int total = 0;
    int fails = 0;

    way_select_controller #(.WAYS(8), .TAG_BITS(12), .SET_BITS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_set      (req_set),
        .req_tag      (req_tag),
        .tag_rd_en    (tag_rd_en),
        .tag_rd_set   (tag_rd_set),
        .way_tags     (way_tags),
        .way_valid    (way_valid),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_hit      (rsp_hit),
        .rsp_way      (rsp_way),
        .rsp_multihit (rsp_multihit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every way holds 0x100+w, never equal to the 0x0AB probe tag.
    function automatic logic [95:0] tags_differ();
        logic [95:0] t;
        for (int w = 0; w < 8; w++) t[w*12 +: 12] = 12'h100 + 12'(w);
        return t;
    endfunction

    task automatic lookup(input string nm, input logic [3:0] set, input logic [11:0] tag,
                          input logic [95:0] tags, input logic [7:0] valid,
                          input logic exp_hit, input logic [2:0] exp_way,
                          input logic exp_mh, input int hold);
        way_tags  = tags;
        way_valid = valid;
        req_set   = set;
        req_tag   = tag;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({nm, ".tag_rd_en"},  32'(tag_rd_en), 32'd1);
        chk({nm, ".tag_rd_set"}, 32'(tag_rd_set), 32'(set));
        chk({nm, ".req_ready0"}, 32'(req_ready), 32'd0);
        chk({nm, ".rsp_valid_n1"}, 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk({nm, ".rsp_valid_n2"}, 32'(rsp_valid), 32'd0);
        chk({nm, ".tag_rd_off"},   32'(tag_rd_en), 32'd0);
        @(posedge clk); #1;
        chk({nm, ".rsp_valid_n3"}, 32'(rsp_valid), 32'd1);
        chk({nm, ".hit"},      32'(rsp_hit), 32'(exp_hit));
        chk({nm, ".way"},      32'(rsp_way), 32'(exp_way));
        chk({nm, ".multihit"}, 32'(rsp_multihit), 32'(exp_mh));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({nm, ".hold_way"},   32'(rsp_way), 32'(exp_way));
            chk({nm, ".hold_hit"},   32'(rsp_hit), 32'(exp_hit));
            chk({nm, ".hold_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({nm, ".done_valid"}, 32'(rsp_valid), 32'd0);
        chk({nm, ".done_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [95:0] t;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_set   = '0;
        req_tag   = '0;
        way_tags  = '0;
        way_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst.req_ready",    32'(req_ready), 32'd1);
        chk("rst.tag_rd_en",    32'(tag_rd_en), 32'd0);
        chk("rst.rsp_valid",    32'(rsp_valid), 32'd0);
        chk("rst.rsp_hit",      32'(rsp_hit), 32'd0);
        chk("rst.rsp_way",      32'(rsp_way), 32'd0);
        chk("rst.rsp_multihit", 32'(rsp_multihit), 32'd0);

        // PLRU sequence on set 3: all-zero tree -> 0, then 4, then 2.
        lookup("miss0", 4'd3, 12'h0AB, tags_differ(), 8'hFF, 1'b0, 3'd0, 1'b0, 0);
        lookup("miss4", 4'd3, 12'h0AB, tags_differ(), 8'hFF, 1'b0, 3'd4, 1'b0, 0);
        lookup("miss2", 4'd3, 12'h0AB, tags_differ(), 8'hFF, 1'b0, 3'd2, 1'b0, 0);

        t = tags_differ();
        t[5*12 +: 12] = 12'h0AB;
        lookup("hit5", 4'd3, 12'h0AB, t, 8'hFF, 1'b1, 3'd5, 1'b0, 0);

        t = tags_differ();
        t[2*12 +: 12] = 12'h0AB;
        t[6*12 +: 12] = 12'h0AB;
        lookup("multi", 4'd3, 12'h0AB, t, 8'hFF, 1'b1, 3'd2, 1'b1, 0);

        // Matching tag on an invalid way must not hit.
        t = tags_differ();
        t[3*12 +: 12] = 12'h0AB;
        lookup("inv3", 4'd3, 12'h0AB, t, 8'hF7, 1'b0, 3'd3, 1'b0, 0);

        // Set 3 tree after accesses 0,4,2,5,2,3 points at way 6; held 5 cycles.
        lookup("plru6", 4'd3, 12'h0AB, tags_differ(), 8'hFF, 1'b0, 3'd6, 1'b0, 5);

        // Untouched set still picks way 0.
        lookup("set5", 4'd5, 12'h0AB, tags_differ(), 8'hFF, 1'b0, 3'd0, 1'b0, 0);

        // Abandon a hit-on-way-5 lookup in COMPARE.
        t = tags_differ();
        t[5*12 +: 12] = 12'h0AB;
        way_tags  = t;
        way_valid = 8'hFF;
        req_set   = 4'd3;
        req_tag   = 12'h0AB;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid.req_ready",    32'(req_ready), 32'd1);
        chk("mid.rsp_valid",    32'(rsp_valid), 32'd0);
        chk("mid.tag_rd_en",    32'(tag_rd_en), 32'd0);
        chk("mid.rsp_hit",      32'(rsp_hit), 32'd0);
        chk("mid.rsp_way",      32'(rsp_way), 32'd0);
        chk("mid.rsp_multihit", 32'(rsp_multihit), 32'd0);
        @(posedge clk); #1;
        chk("mid.idle_hold",    32'(req_ready), 32'd1);
        lookup("postrst", 4'd3, 12'h0AB, tags_differ(), 8'hFF, 1'b0, 3'd0, 1'b0, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
